// File: rtl/scope_capture.sv
// Triggered single-frame capture buffer for the scope display. It waits for a level
// crossing (or an auto-trigger timeout), stores DEPTH decimated samples, then freezes them.
module scope_capture #(
  parameter int DEPTH   = 640,
  parameter int AW      = 10,
  parameter int DECIM   = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic signed [7:0]   sample_in,
  input  logic                sample_valid,
  input  logic signed [7:0]   trig_level,
  input  logic                trig_slope,
  input  logic                auto_en,
  input  logic                arm,
  input  logic [AW-1:0]       rd_addr,
  output logic signed [7:0]   rd_data,
  output logic                frame_ready,
  output logic                busy,
  output logic                auto_trig
);

  localparam int TW = $clog2(TIMEOUT + 1) + 1;
  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [7:0]    DECIM_LAST = 8'(DECIM - 1);
  localparam logic [TW-1:0] TIMEOUT_W  = TW'(TIMEOUT);
  localparam logic [AW:0]   DEPTH_W    = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_TRIG, S_CAPTURE, S_HOLD} state_e;

  state_e            state_q, state_d;
  logic signed [7:0] prev_q, prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [7:0]        decim_q, decim_d;
  logic              auto_next_q, auto_next_d;
  logic              frame_ready_q, frame_ready_d;
  logic              busy_q, busy_d;
  logic              auto_trig_q, auto_trig_d;
  logic signed [7:0] rd_data_q, rd_data_d;

  logic              we;
  logic [AW-1:0]     wr_addr;
  logic [7:0]        wr_data;
  logic [TW-1:0]     tcnt_inc;
  logic              lvl_hit;
  logic              time_hit;

  logic [7:0] mem [DEPTH];

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_d       = state_q;
    prev_d        = prev_q;
    prev_valid_d  = prev_valid_q;
    tcnt_d        = tcnt_q;
    addr_d        = addr_q;
    decim_d       = decim_q;
    auto_next_d   = auto_next_q;
    frame_ready_d = frame_ready_q;
    auto_trig_d   = auto_trig_q;
    we            = 1'b0;
    wr_addr       = addr_q;
    wr_data       = sample_in;

    lvl_hit  = trig_slope ? ((prev_q > trig_level) && (sample_in <= trig_level))
                          : ((prev_q < trig_level) && (sample_in >= trig_level));
    tcnt_inc = tcnt_q + 1'b1;
    time_hit = auto_en && (tcnt_inc >= TIMEOUT_W);

    unique case (state_q)
      S_IDLE: begin
        prev_valid_d = 1'b0;
        tcnt_d       = '0;
        addr_d       = '0;
        if (arm) state_d = S_WAIT_TRIG;
      end

      S_WAIT_TRIG: begin
        if (sample_valid) begin
          prev_d = sample_in;
          if (!prev_valid_q) begin
            prev_valid_d = 1'b1;
          end else if (lvl_hit || time_hit) begin
            we          = 1'b1;
            wr_addr     = '0;
            decim_d     = '0;
            addr_d      = AW'(1);
            auto_next_d = !lvl_hit;
            if (DEPTH == 1) begin
              state_d       = S_HOLD;
              frame_ready_d = 1'b1;
              auto_trig_d   = !lvl_hit;
            end else begin
              state_d = S_CAPTURE;
            end
          end else begin
            // Saturate so a long wait with auto_en low never wraps the counter.
            tcnt_d = (tcnt_inc >= TIMEOUT_W) ? TIMEOUT_W : tcnt_inc;
          end
        end
      end

      S_CAPTURE: begin
        if (sample_valid) begin
          if (decim_q == DECIM_LAST) begin
            decim_d = '0;
            we      = 1'b1;
            addr_d  = addr_q + 1'b1;
            if (addr_q == LAST_ADDR) begin
              state_d       = S_HOLD;
              frame_ready_d = 1'b1;
              auto_trig_d   = auto_next_q;
            end
          end else begin
            decim_d = decim_q + 8'd1;
          end
        end
      end

      S_HOLD: begin
        if (arm) begin
          state_d       = S_WAIT_TRIG;
          prev_valid_d  = 1'b0;
          tcnt_d        = '0;
          addr_d        = '0;
          frame_ready_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d    = (state_d == S_WAIT_TRIG) || (state_d == S_CAPTURE);
    rd_data_d = ({1'b0, rd_addr} < DEPTH_W) ? mem[rd_addr] : 8'sd0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      prev_q        <= '0;
      prev_valid_q  <= 1'b0;
      tcnt_q        <= '0;
      addr_q        <= '0;
      decim_q       <= '0;
      auto_next_q   <= 1'b0;
      frame_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      auto_trig_q   <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      prev_valid_q  <= prev_valid_d;
      tcnt_q        <= tcnt_d;
      addr_q        <= addr_d;
      decim_q       <= decim_d;
      auto_next_q   <= auto_next_d;
      frame_ready_q <= frame_ready_d;
      busy_q        <= busy_d;
      auto_trig_q   <= auto_trig_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // NOTE: the sample RAM has no reset so it maps onto block RAM; a partial frame survives reset.
  always_ff @(posedge CLOCK_50) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data     = rd_data_q;
  assign frame_ready = frame_ready_q;
  assign busy        = busy_q;
  assign auto_trig   = auto_trig_q;

endmodule

// File: tb/tb_scope_capture.sv
// Directed bench for scope_capture with a small frame (DEPTH=6, DECIM=2, TIMEOUT=4).
module tb_scope_capture;
  localparam int DEPTH   = 6;
  localparam int AW      = 3;
  localparam int DECIM   = 2;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] sample_in;
  logic              sample_valid;
  logic signed [7:0] trig_level;
  logic              trig_slope;
  logic              auto_en;
  logic              arm;
  logic [AW-1:0]     rd_addr;
  logic signed [7:0] rd_data;
  logic              frame_ready;
  logic              busy;
  logic              auto_trig;

  int n_checks = 0;
  int n_fail   = 0;

  scope_capture #(.DEPTH(DEPTH), .AW(AW), .DECIM(DECIM), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK_50    (clk),
    .reset       (rst),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .trig_level  (trig_level),
    .trig_slope  (trig_slope),
    .auto_en     (auto_en),
    .arm         (arm),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_ready (frame_ready),
    .busy        (busy),
    .auto_trig   (auto_trig)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then settle just after the rising edge.
  task automatic step(input logic signed [7:0] s, input logic v, input logic a);
    @(negedge clk);
    sample_in    = s;
    sample_valid = v;
    arm          = a;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    arm          = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [AW-1:0] a, input logic [7:0] exp);
    @(negedge clk);
    rd_addr = a;
    step(8'sd0, 1'b0, 1'b0);
    check(tag, rd_data, exp);
  endtask

  task automatic status(input string tag, input logic fr, input logic bz, input logic at);
    check({tag, "_frame_ready"}, {7'd0, frame_ready}, {7'd0, fr});
    check({tag, "_busy"},        {7'd0, busy},        {7'd0, bz});
    check({tag, "_auto_trig"},   {7'd0, auto_trig},   {7'd0, at});
  endtask

  initial begin
    rst = 1'b1; sample_in = '0; sample_valid = 1'b0; trig_level = '0;
    trig_slope = 1'b0; auto_en = 1'b0; arm = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    check("reset_rd_data", rd_data, 8'h00);
    status("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Rising through 0, sparse valids during capture, arm pulses ignored.
    step(8'sd0, 1'b0, 1'b1);
    status("a_armed", 1'b0, 1'b1, 1'b0);
    step(-8'sd3, 1'b1, 1'b0);
    step(-8'sd2, 1'b1, 1'b1);
    step(-8'sd1, 1'b1, 1'b0);
    step(8'sd0, 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(8'(i), 1'b1, (i == 3 || i == 10));
      if (i == 9) status("a_pre_done", 1'b0, 1'b1, 1'b0);
      step(8'sd0, 1'b0, 1'b0);
    end
    status("a_done", 1'b1, 1'b0, 1'b0);
    step(8'sd99, 1'b1, 1'b0);
    step(8'sd98, 1'b1, 1'b0);
    status("a_hold", 1'b1, 1'b0, 1'b0);
    read_chk("a_mem0", 3'd0, 8'd0);
    read_chk("a_mem1", 3'd1, 8'd2);
    read_chk("a_mem5", 3'd5, 8'd10);
    read_chk("a_oob6", 3'd6, 8'd0);
    read_chk("a_oob7", 3'd7, 8'd0);

    // Falling through -16; equality on the previous sample must not fire.
    trig_slope = 1'b1; trig_level = -8'sd16;
    rd_addr = 3'd0;
    step(8'sd0, 1'b0, 1'b1);
    status("b_armed", 1'b0, 1'b1, 1'b0);
    step(-8'sd30, 1'b1, 1'b0);
    step(-8'sd16, 1'b1, 1'b0);
    step(-8'sd20, 1'b1, 1'b0);
    step(-8'sd5, 1'b1, 1'b0);
    step(-8'sd16, 1'b1, 1'b0);
    check("b_collision_old", rd_data, 8'h00);
    for (int i = 1; i <= 10; i++) step(8'(-5 * i), 1'b1, 1'b0);
    status("b_done", 1'b1, 1'b0, 1'b0);
    read_chk("b_mem0", 3'd0, 8'hF0);
    read_chk("b_mem3", 3'd3, 8'hE2);
    read_chk("b_mem5", 3'd5, 8'hCE);

    // Auto-trigger on the 5th valid sample after arm with a flat input.
    trig_slope = 1'b0; trig_level = 8'sd0; auto_en = 1'b1;
    step(8'sd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(8'sd7, 1'b1, 1'b0);
    status("c_waiting", 1'b0, 1'b1, 1'b0);
    step(8'sd9, 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(8'sd3, 1'b1, 1'b0);
      if (i == 9) status("c_pre_done", 1'b0, 1'b1, 1'b0);
    end
    status("c_done", 1'b1, 1'b0, 1'b1);
    read_chk("c_mem0", 3'd0, 8'd9);
    read_chk("c_mem4", 3'd4, 8'd3);

    // Without auto_en a flat input never triggers.
    auto_en = 1'b0;
    step(8'sd0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(8'sd7, 1'b1, 1'b0);
    status("d_no_auto", 1'b0, 1'b1, 1'b1);

    // Trigger, capture a little, then reset asynchronously mid-frame.
    step(-8'sd1, 1'b1, 1'b0);
    step(8'sd1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(8'(50 + i), 1'b1, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("d_rst_rd_data", rd_data, 8'h00);
    status("d_rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    read_chk("d_mem0", 3'd0, 8'd1);
    read_chk("d_mem1", 3'd1, 8'd51);
    read_chk("d_mem2", 3'd2, 8'd53);
    read_chk("d_mem3", 3'd3, 8'd3);

    // After reset the first sample only primes; 5 must not trigger at level 1.
    trig_level = 8'sd1;
    step(8'sd0, 1'b0, 1'b1);
    step(8'sd5, 1'b1, 1'b0);
    step(8'sd6, 1'b1, 1'b0);
    step(8'sd7, 1'b1, 1'b0);
    step(8'sd0, 1'b1, 1'b0);
    step(8'sd2, 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(8'(20 + i), 1'b1, 1'b0);
      if (i == 9) status("e_pre_done", 1'b0, 1'b1, 1'b0);
    end
    status("e_done", 1'b1, 1'b0, 1'b0);
    read_chk("e_mem0", 3'd0, 8'd2);
    read_chk("e_mem5", 3'd5, 8'd30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
